// File: rtl/seq_divider.sv
// seq_divider: 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a division (accepted only while idle)
//   dividend     in   8-bit unsigned numerator, sampled on accept
//   divisor      in   4-bit unsigned denominator, sampled on accept
//   quotient     out  8-bit registered quotient
//   remainder    out  4-bit registered remainder
//   busy         out  high in CALC and DONE
//   done         out  one-cycle pulse while quotient/remainder are valid
//   div_by_zero  out  registered flag, last accepted divisor was zero
//
// A zero divisor skips CALC entirely and reports quotient 8'hFF, remainder 4'hF.

module seq_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] dvd_q, dvd_d;     // dividend, shifted left so bit 7 is the next bit in
    logic [3:0] dvs_q, dvs_d;
    logic [4:0] prem_q, prem_d;   // partial remainder; stored value is always < divisor
    logic [7:0] quo_q, quo_d;
    logic       dbz_q, dbz_d;

    logic [4:0] shifted;
    logic       fits;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (divisor == 4'd0) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                done = 1'b0;
            end
            StCalc: begin
                busy = 1'b1;
                done = 1'b0;
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        shifted = (prem_q << 1) | {4'b0000, dvd_q[7]};
        fits    = (shifted >= {1'b0, dvs_q});
    end

    // Datapath next-state
    always_comb begin
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        prem_d = prem_q;
        quo_d  = quo_q;
        dbz_d  = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d = 3'd0;
                    dvd_d = dividend;
                    dvs_d = divisor;
                    if (divisor == 4'd0) begin
                        quo_d  = 8'hFF;
                        prem_d = 5'h0F;
                        dbz_d  = 1'b1;
                    end else begin
                        quo_d  = 8'h00;
                        prem_d = 5'h00;
                        dbz_d  = 1'b0;
                    end
                end
            end
            StCalc: begin
                dvd_d  = {dvd_q[6:0], 1'b0};
                prem_d = fits ? (shifted - {1'b0, dvs_q}) : shifted;
                quo_d  = {quo_q[6:0], fits};
                cnt_d  = cnt_q + 3'd1;  // wraps 7 -> 0 on the final step
            end
            StDone: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 3'd0;
            dvd_q  <= 8'h00;
            dvs_q  <= 4'h0;
            prem_q <= 5'h00;
            quo_q  <= 8'h00;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            prem_q <= prem_d;
            quo_q  <= quo_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = prem_q[3:0];
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed table, corner-case sequences and a full operand sweep for seq_divider.
// Latency is counted so that the first cycle after the accepting edge is cycle 1;
// done is expected in cycle 9 (nonzero divisor) or cycle 1 (zero divisor).

module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        logic [4:0] lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Run one division from idle. Inputs are scrambled right after accept.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                           output logic [7:0] q, output logic [3:0] r, output logic dbz,
                           output int lat, output logic busy_ok, output logic idle_ok);
        busy_ok = 1'b1;
        lat     = 99;
        q       = 8'h00;
        r       = 4'h0;
        dbz     = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = b + 4'd3;
        for (int n = 1; n <= 20; n++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = n;
                q   = quotient;
                r   = remainder;
                dbz = div_by_zero;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        idle_ok = !done && !busy;
    endtask

    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
    logic       busy_ok;
    logic       idle_ok;

    initial begin
        vecs[0]  = '{8'd225, 4'd15, 8'd15,  4'd0,  1'b0, 5'd9};
        vecs[1]  = '{8'd100, 4'd7,  8'd14,  4'd2,  1'b0, 5'd9};
        vecs[2]  = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 5'd9};
        vecs[3]  = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0, 5'd9};
        vecs[4]  = '{8'd5,   4'd0,  8'hFF,  4'hF,  1'b1, 5'd1};
        vecs[5]  = '{8'd12,  4'd4,  8'd3,   4'd0,  1'b0, 5'd9};
        vecs[6]  = '{8'd63,  4'd8,  8'd7,   4'd7,  1'b0, 5'd9};
        vecs[7]  = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0, 5'd9};
        vecs[8]  = '{8'd1,   4'd15, 8'd0,   4'd1,  1'b0, 5'd9};
        vecs[9]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 5'd9};
        vecs[10] = '{8'd128, 4'd3,  8'd42,  4'd2,  1'b0, 5'd9};
        vecs[11] = '{8'd7,   4'd8,  8'd0,   4'd7,  1'b0, 5'd9};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'h00;
        divisor  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset quotient", int'(quotient), 0);
        chk("reset remainder", int'(remainder), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset div_by_zero", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].dvd, vecs[i].dvs, q, r, dbz, lat, busy_ok, idle_ok);
            chk($sformatf("vec%0d quotient", i), int'(q), int'(vecs[i].q));
            chk($sformatf("vec%0d remainder", i), int'(r), int'(vecs[i].r));
            chk($sformatf("vec%0d div_by_zero", i), int'(dbz), int'(vecs[i].dbz));
            chk($sformatf("vec%0d latency", i), lat, int'(vecs[i].lat));
            chk($sformatf("vec%0d busy while active", i), int'(busy_ok), 1);
            chk($sformatf("vec%0d idle after done", i), int'(idle_ok), 1);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("vec%0d quotient hold", i), int'(quotient), int'(vecs[i].q));
            chk($sformatf("vec%0d remainder hold", i), int'(remainder), int'(vecs[i].r));
            chk($sformatf("vec%0d flag hold", i), int'(div_by_zero), int'(vecs[i].dbz));
        end

        // start during CALC is ignored: 200/9 with 50/3 presented mid-division
        begin
            int ndone;
            int dlat;
            ndone = 0;
            dlat  = 0;
            @(negedge clk);
            start    = 1'b1;
            dividend = 8'd200;
            divisor  = 4'd9;
            @(posedge clk);
            #1;
            dividend = 8'd50;
            divisor  = 4'd3;
            for (int n = 1; n <= 15; n++) begin
                if (n == 6) start = 1'b0;
                if (done) begin
                    ndone++;
                    dlat = n;
                    q    = quotient;
                    r    = remainder;
                end
                @(posedge clk);
                #1;
            end
            chk("ignore-start done count", ndone, 1);
            chk("ignore-start latency", dlat, 9);
            chk("ignore-start quotient", int'(q), 22);
            chk("ignore-start remainder", int'(r), 2);
            chk("ignore-start idle", int'(busy), 0);
        end

        // start held high: back-to-back divisions every 10 cycles
        begin
            int first;
            int second;
            first  = -1;
            second = -1;
            @(negedge clk);
            start    = 1'b1;
            dividend = 8'd12;
            divisor  = 4'd4;
            for (int n = 0; n < 30; n++) begin
                @(posedge clk);
                #1;
                if (done) begin
                    if (first < 0) first = n;
                    else if (second < 0) second = n;
                end
            end
            start = 1'b0;
            chk("back-to-back period", second - first, 10);
            chk("back-to-back quotient", int'(quotient), 3);
            for (int n = 0; n < 12 && busy; n++) begin
                @(posedge clk);
                #1;
            end
            chk("back-to-back drains", int'(busy), 0);
        end

        // Reset during the 4th CALC cycle aborts the division
        begin
            int ndone;
            ndone = 0;
            @(negedge clk);
            start    = 1'b1;
            dividend = 8'd200;
            divisor  = 4'd9;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (3) @(posedge clk);
            #3;
            rst_n = 1'b0;
            #1;
            chk("abort quotient", int'(quotient), 0);
            chk("abort remainder", int'(remainder), 0);
            chk("abort busy", int'(busy), 0);
            chk("abort done", int'(done), 0);
            chk("abort div_by_zero", int'(div_by_zero), 0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int n = 0; n < 12; n++) begin
                @(posedge clk);
                #1;
                if (done || busy) ndone++;
            end
            chk("abort no done after release", ndone, 0);
            run_div(8'd63, 4'd8, q, r, dbz, lat, busy_ok, idle_ok);
            chk("post-abort quotient", int'(q), 7);
            chk("post-abort remainder", int'(r), 7);
            chk("post-abort latency", lat, 9);
        end

        // Full operand sweep against an arithmetic reference
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [7:0] eq;
                logic [3:0] er;
                logic       ed;
                int         el;
                if (b == 0) begin
                    eq = 8'hFF;
                    er = 4'hF;
                    ed = 1'b1;
                    el = 1;
                end else begin
                    eq = 8'(a / b);
                    er = 4'(a % b);
                    ed = 1'b0;
                    el = 9;
                end
                run_div(a[7:0], b[3:0], q, r, dbz, lat, busy_ok, idle_ok);
                checks++;
                if (q !== eq || r !== er || dbz !== ed || lat != el || !busy_ok || !idle_ok) begin
                    errors++;
                    $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%0d lat=%0d busy_ok=%0d idle_ok=%0d expected q=%0d r=%0d dbz=%0d lat=%0d",
                             a, b, q, r, dbz, lat, busy_ok, idle_ok, eq, er, ed, el);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
